// File: rtl/gestor_interrupciones_if.sv
// Signal bundle between the interrupt controller and the CPU-side logic.
// Request/accept: int_req stays high with vector/irq_id stable until int_ack (accept) or withdrawal.
interface gestor_interrupciones_if #(
  parameter int N_IRQ    = 3,
  parameter int PC_WIDTH = 10
);
  logic [N_IRQ-1:0]    irq;
  logic                ire;
  logic                mask_we;
  logic [N_IRQ-1:0]    mask_wd;
  logic                int_ack;
  logic                reti;
  logic                int_req;
  logic [PC_WIDTH-1:0] vector;
  logic [1:0]          irq_id;
  logic [N_IRQ-1:0]    pending;
  logic [N_IRQ-1:0]    in_service;
  logic                lost;
  logic [1:0]          state_dbg;

  modport master (
    output irq, ire, mask_we, mask_wd, int_ack, reti,
    input  int_req, vector, irq_id, pending, in_service, lost, state_dbg
  );

  modport slave (
    input  irq, ire, mask_we, mask_wd, int_ack, reti,
    output int_req, vector, irq_id, pending, in_service, lost, state_dbg
  );
endinterface

// File: rtl/gestor_interrupciones.sv
// Fixed-priority interrupt controller: synchronizes and edge-detects request lines,
// queues them as pending, and presents one masked request with its vector to the CPU.
module gestor_interrupciones #(
  parameter int                  N_IRQ      = 3,
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] VEC_BASE   = 'h3F0,
  parameter int                  VEC_STRIDE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  gestor_interrupciones_if.slave  bus
);
  localparam int IDW = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_IRQ-1:0]    s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic [N_IRQ-1:0]    mask_q, mask_d;
  logic [N_IRQ-1:0]    in_service_q, in_service_d;
  logic                int_req_q, int_req_d;
  logic [PC_WIDTH-1:0] vector_q, vector_d;
  logic [IDW-1:0]      irq_id_q, irq_id_d;
  logic                lost_q, lost_d;

  logic [N_IRQ-1:0]    edge_det;
  logic [N_IRQ-1:0]    eligible;
  logic [N_IRQ-1:0]    latched_bit;
  logic [N_IRQ-1:0]    ack_clear;
  logic [IDW-1:0]      winner;

  assign edge_det    = s2_q & ~s3_q;
  assign eligible    = pending_q & mask_q;
  assign latched_bit = N_IRQ'(1) << irq_id_q;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    ack_clear    = '0;
    case (state_q)
      IDLE: begin
        if (bus.ire && (|eligible)) begin
          irq_id_d  = winner;
          vector_d  = VEC_BASE + PC_WIDTH'(VEC_STRIDE) * PC_WIDTH'(winner);
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          ack_clear    = latched_bit;
          in_service_d = latched_bit;
          int_req_d    = 1'b0;
          state_d      = SERVICE;
        end else if (!bus.ire || !(|(eligible & latched_bit))) begin
          int_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICE: begin
        if (bus.reti) begin
          in_service_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge wins over an ack clear on the same bit, so it is queued, not lost.
  always_comb begin
    pending_d = (pending_q & ~ack_clear) | edge_det;
    mask_d    = bus.mask_we ? bus.mask_wd : mask_q;
    lost_d    = bus.mask_we ? 1'b0 : lost_q;
    if (|(edge_det & pending_q & ~ack_clear)) lost_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      in_service_q <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      irq_id_q     <= '0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= bus.irq;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      irq_id_q     <= irq_id_d;
      lost_q       <= lost_d;
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.vector     = vector_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.lost       = lost_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_gestor_interrupciones.sv
// Bench for gestor_interrupciones: directed vector table, hand-written corner sequences,
// then random traffic against a behavioural model of the controller.
module tb_gestor_interrupciones;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gestor_interrupciones_if #(.N_IRQ(3), .PC_WIDTH(10)) bus ();
  gestor_interrupciones dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [2:0] m_h1, m_h2, m_h3;
  logic [2:0] m_pend, m_mask, m_insvc;
  logic       m_req, m_lost;
  logic [9:0] m_vec;
  int         m_src;
  bit         m_waiting, m_serving;

  function automatic logic [9:0] vec_of(input int idx);
    return 10'((1008 + 4 * idx) % 1024);
  endfunction

  task automatic model_step();
    logic [2:0] rise, ok, cleared;
    int w;
    if (reset) begin
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_pend = 0; m_mask = 3'b111; m_insvc = 0;
      m_req = 0; m_lost = 0; m_vec = 0; m_src = 0;
      m_waiting = 0; m_serving = 0;
    end else begin
      rise    = m_h2 & ~m_h3;
      ok      = m_pend & m_mask;
      cleared = 0;
      if (m_waiting) begin
        if (bus.int_ack) begin
          cleared[m_src] = 1'b1;
          m_insvc = 0;
          m_insvc[m_src] = 1'b1;
          m_waiting = 0; m_serving = 1; m_req = 0;
        end else if (!bus.ire || !ok[m_src]) begin
          m_waiting = 0; m_req = 0;
        end
      end else if (m_serving) begin
        if (bus.reti) begin
          m_serving = 0; m_insvc = 0;
        end
      end else if (bus.ire && ok != 0) begin
        w = -1;
        for (int i = 0; i < 3; i++) if (w < 0 && ok[i]) w = i;
        m_src = w; m_vec = vec_of(w); m_req = 1; m_waiting = 1;
      end
      if (bus.mask_we) m_lost = 0;
      if ((rise & m_pend & ~cleared) != 0) m_lost = 1;
      m_pend = (m_pend & ~cleared) | rise;
      if (bus.mask_we) m_mask = bus.mask_wd;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.irq;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("int_req",    32'(bus.int_req),    32'(m_req));
    chk("vector",     32'(bus.vector),     32'(m_vec));
    chk("irq_id",     32'(bus.irq_id),     32'(m_src));
    chk("pending",    32'(bus.pending),    32'(m_pend));
    chk("in_service", 32'(bus.in_service), 32'(m_insvc));
    chk("lost",       32'(bus.lost),       32'(m_lost));
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic rst, input logic [2:0] irq, input logic ire,
                        input logic mwe, input logic [2:0] mwd, input logic ack, input logic rti);
    reset       = rst;
    bus.irq     = irq;
    bus.ire     = ire;
    bus.mask_we = mwe;
    bus.mask_wd = mwd;
    bus.int_ack = ack;
    bus.reti    = rti;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic run(input logic rst, input logic [2:0] irq, input logic ire,
                     input logic mwe, input logic [2:0] mwd, input logic ack, input logic rti);
    set_in(rst, irq, ire, mwe, mwd, ack, rti);
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [2:0] irq;
    logic       ire;
    logic       mwe;
    logic [2:0] mwd;
    logic       ack;
    logic       rti;
    logic       e_req;
    logic [9:0] e_vec;
    logic [1:0] e_id;
    logic [2:0] e_pend;
    logic [2:0] e_insvc;
  } vec_t;

  localparam int NTBL = 27;
  vec_t tbl[NTBL];

  function automatic vec_t mk(input logic rst, input logic [2:0] irq, input logic ire,
                              input logic mwe, input logic [2:0] mwd, input logic ack,
                              input logic rti, input logic e_req, input logic [9:0] e_vec,
                              input logic [1:0] e_id, input logic [2:0] e_pend,
                              input logic [2:0] e_insvc);
    vec_t v;
    v.rst = rst; v.irq = irq; v.ire = ire; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.rti = rti;
    v.e_req = e_req; v.e_vec = e_vec; v.e_id = e_id; v.e_pend = e_pend; v.e_insvc = e_insvc;
    return v;
  endfunction

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 3'b000, 1, 0, 0, 0, 0,  0, 10'h000, 0, 3'b000, 3'b000);
    tbl[1]  = mk(0, 3'b010, 1, 0, 0, 0, 0,  0, 10'h000, 0, 3'b000, 3'b000);
    tbl[2]  = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h000, 0, 3'b000, 3'b000);
    tbl[3]  = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h000, 0, 3'b010, 3'b000);
    tbl[4]  = mk(0, 3'b000, 1, 0, 0, 0, 0,  1, 10'h3F4, 1, 3'b010, 3'b000);
    tbl[5]  = mk(0, 3'b000, 1, 0, 0, 1, 0,  0, 10'h3F4, 1, 3'b000, 3'b010);
    tbl[6]  = mk(0, 3'b000, 1, 0, 0, 0, 1,  0, 10'h3F4, 1, 3'b000, 3'b000);
    tbl[7]  = mk(0, 3'b101, 1, 0, 0, 0, 0,  0, 10'h3F4, 1, 3'b000, 3'b000);
    tbl[8]  = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h3F4, 1, 3'b000, 3'b000);
    tbl[9]  = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h3F4, 1, 3'b101, 3'b000);
    tbl[10] = mk(0, 3'b000, 1, 0, 0, 0, 0,  1, 10'h3F0, 0, 3'b101, 3'b000);
    tbl[11] = mk(0, 3'b000, 1, 0, 0, 1, 0,  0, 10'h3F0, 0, 3'b100, 3'b001);
    tbl[12] = mk(0, 3'b000, 1, 0, 0, 0, 1,  0, 10'h3F0, 0, 3'b100, 3'b000);
    tbl[13] = mk(0, 3'b000, 1, 0, 0, 0, 0,  1, 10'h3F8, 2, 3'b100, 3'b000);
    tbl[14] = mk(0, 3'b000, 1, 0, 0, 1, 0,  0, 10'h3F8, 2, 3'b000, 3'b100);
    tbl[15] = mk(0, 3'b000, 1, 0, 0, 0, 1,  0, 10'h3F8, 2, 3'b000, 3'b000);
    tbl[16] = mk(0, 3'b000, 1, 1, 3'b110, 0, 0,  0, 10'h3F8, 2, 3'b000, 3'b000);
    tbl[17] = mk(0, 3'b001, 1, 0, 0, 0, 0,  0, 10'h3F8, 2, 3'b000, 3'b000);
    tbl[18] = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h3F8, 2, 3'b000, 3'b000);
    tbl[19] = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h3F8, 2, 3'b001, 3'b000);
    tbl[20] = mk(0, 3'b000, 1, 0, 0, 0, 0,  0, 10'h3F8, 2, 3'b001, 3'b000);
    tbl[21] = mk(0, 3'b000, 1, 1, 3'b111, 0, 0,  0, 10'h3F8, 2, 3'b001, 3'b000);
    tbl[22] = mk(0, 3'b000, 1, 0, 0, 0, 0,  1, 10'h3F0, 0, 3'b001, 3'b000);
    tbl[23] = mk(0, 3'b000, 0, 0, 0, 0, 0,  0, 10'h3F0, 0, 3'b001, 3'b000);
    tbl[24] = mk(0, 3'b000, 1, 0, 0, 0, 0,  1, 10'h3F0, 0, 3'b001, 3'b000);
    tbl[25] = mk(0, 3'b000, 1, 0, 0, 1, 0,  0, 10'h3F0, 0, 3'b000, 3'b001);
    tbl[26] = mk(0, 3'b000, 1, 0, 0, 0, 1,  0, 10'h3F0, 0, 3'b000, 3'b000);

    for (int r = 0; r < NTBL; r++) begin
      run(tbl[r].rst, tbl[r].irq, tbl[r].ire, tbl[r].mwe, tbl[r].mwd, tbl[r].ack, tbl[r].rti);
      chk($sformatf("tbl%0d.int_req", r),    32'(bus.int_req),    32'(tbl[r].e_req));
      chk($sformatf("tbl%0d.vector", r),     32'(bus.vector),     32'(tbl[r].e_vec));
      chk($sformatf("tbl%0d.irq_id", r),     32'(bus.irq_id),     32'(tbl[r].e_id));
      chk($sformatf("tbl%0d.pending", r),    32'(bus.pending),    32'(tbl[r].e_pend));
      chk($sformatf("tbl%0d.in_service", r), 32'(bus.in_service), 32'(tbl[r].e_insvc));
    end

    // Higher-priority arrival during REQ must not re-arbitrate.
    run(0, 3'b100, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    chk("hold.req_src2", 32'(bus.vector), 32'h3F8);
    run(0, 3'b001, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run(0, 3'b000, 1, 0, 0, 0, 0);
      chk("hold.vector", 32'(bus.vector), 32'h3F8);
      chk("hold.int_req", 32'(bus.int_req), 32'h1);
    end
    chk("hold.pending", 32'(bus.pending), 32'h5);
    run(0, 3'b000, 1, 0, 0, 1, 0);
    run(0, 3'b000, 1, 0, 0, 0, 1);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    chk("hold.next_vec", 32'(bus.vector), 32'h3F0);
    chk("hold.next_id",  32'(bus.irq_id), 32'h0);
    run(0, 3'b000, 1, 0, 0, 1, 0);
    run(0, 3'b000, 1, 0, 0, 0, 1);

    // Second edge on an already-pending source sets the sticky lost flag.
    run(0, 3'b010, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b010, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    chk("lost.before", 32'(bus.lost), 32'h0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    chk("lost.set", 32'(bus.lost), 32'h1);
    run(0, 3'b000, 1, 0, 0, 1, 0);
    run(0, 3'b000, 1, 0, 0, 0, 1);
    chk("lost.sticky", 32'(bus.lost), 32'h1);
    run(0, 3'b000, 1, 1, 3'b111, 0, 0);
    chk("lost.clear", 32'(bus.lost), 32'h0);
    run(0, 3'b000, 1, 0, 0, 0, 0);

    // Reset while in SERVICE with other work pending.
    run(0, 3'b011, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 0, 0);
    run(0, 3'b000, 1, 0, 0, 1, 0);
    chk("rst.pre_insvc", 32'(bus.in_service), 32'h1);
    chk("rst.pre_pend",  32'(bus.pending),    32'h2);
    run(1, 3'b000, 1, 0, 0, 0, 0);
    chk("rst.int_req", 32'(bus.int_req), 32'h0);
    chk("rst.vector",  32'(bus.vector),  32'h0);
    chk("rst.pend",    32'(bus.pending), 32'h0);
    chk("rst.insvc",   32'(bus.in_service), 32'h0);
    run(0, 3'b000, 1, 0, 0, 0, 1);
    chk("rst.reti_ign", 32'(bus.in_service), 32'h0);
    run(0, 3'b000, 1, 0, 0, 1, 0);
    chk("rst.ack_ign", 32'(bus.pending), 32'h0);
    chk("rst.no_req",  32'(bus.int_req), 32'h0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] ri;
      ri = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      set_in($urandom_range(0, 199) == 0,
             ri,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 19) == 0,
             3'($urandom_range(0, 7)),
             m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
